// File: rtl/five12_pkg.sv
`default_nettype none
// ============================================================================
// Module      : five12_pkg
// Description : Shared constants, FSM state encodings and the frame character
//               encoder for the game-state UART reporter.
//               Build macro: TX_PARITY_EN adds the even-parity bit state.
// Revision    : 1.0 - initial release
// ============================================================================
package five12_pkg;

  localparam int CELL_W    = 3;
  localparam int NUM_CELLS = 9;
  localparam int GRID_W    = CELL_W * NUM_CELLS;

  localparam logic [7:0] CHAR_ZERO = 8'h30;  // '0'
  localparam logic [7:0] CHAR_LOSE = 8'h4C;  // 'L'
  localparam logic [7:0] CHAR_PLAY = 8'h50;  // 'P'
  localparam logic [7:0] CHAR_LF   = 8'h0A;  // line feed

  // Per-byte serialiser states
  typedef enum logic [2:0] {
    BYTE_IDLE   = 3'd0,
    BYTE_START  = 3'd1,
    BYTE_DATA   = 3'd2,
    BYTE_STOP   = 3'd3
`ifdef TX_PARITY_EN
    , BYTE_PARITY = 3'd4
`endif
  } byte_state_t;

  // Frame sequencer states
  typedef enum logic [1:0] {
    FRAME_IDLE = 2'd0,
    FRAME_BYTE = 2'd1,
    FRAME_NEXT = 2'd2
  } frame_state_t;

  // Character at position idx of the frame: cells, then status, then LF.
  function automatic logic [7:0] frame_char(input logic [3:0]        idx,
                                            input logic [GRID_W-1:0] g,
                                            input logic              l);
    logic [7:0] c;
    c = CHAR_LF;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == 4'(i)) begin
        c = CHAR_ZERO + {5'd0, g[i*CELL_W +: CELL_W]};
      end
    end
    if (idx == 4'(NUM_CELLS)) begin
      c = l ? CHAR_LOSE : CHAR_PLAY;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_tx
// Description : Single-byte UART serialiser, LSB first, idle high. A start
//               pulse while idle loads the byte and drives the start bit on
//               the very next cycle. o_done marks the last stop-bit cycle.
//               Build macro: TX_PARITY_EN inserts an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
  import five12_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_done
);

  localparam int                  c_BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

  byte_state_t         r_state;
  byte_state_t         w_state_nxt;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic                w_tx_nxt;
  logic                w_done;
  logic                w_bit_end;
`ifdef TX_PARITY_EN
  logic                r_parity;
`endif

  assign w_bit_end = (r_baud == c_BAUD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BYTE_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next line level; the line value is registered below
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_done      = 1'b0;
    case (r_state)
      BYTE_IDLE: begin
        w_tx_nxt = 1'b1;
        if (i_start) begin
          w_state_nxt = BYTE_START;
          w_tx_nxt    = 1'b0;
        end
      end
      BYTE_START: begin
        if (w_bit_end) begin
          w_state_nxt = BYTE_DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      BYTE_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
`ifdef TX_PARITY_EN
            w_state_nxt = BYTE_PARITY;
            w_tx_nxt    = r_parity;
`else
            w_state_nxt = BYTE_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            // r_shift[0] is the bit on the line now; the next one sits above it
            w_tx_nxt = r_shift[1];
          end
        end
      end
`ifdef TX_PARITY_EN
      BYTE_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = BYTE_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      BYTE_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = BYTE_IDLE;
          w_done      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = BYTE_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // Baud counter, bit counter, shift register and the registered line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx     <= 1'b1;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
`ifdef TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_tx <= w_tx_nxt;
      if (r_state == BYTE_IDLE) begin
        r_baud <= '0;
        r_bit  <= '0;
        if (i_start) begin
          r_shift  <= i_data;
`ifdef TX_PARITY_EN
          r_parity <= ^i_data;
`endif
        end
      end else begin
        r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
        if ((r_state == BYTE_DATA) && w_bit_end) begin
          r_bit   <= r_bit + 3'd1;
          r_shift <= {1'b0, r_shift[7:1]};
        end
      end
    end
  end

  assign o_tx   = r_tx;
  assign o_done = w_done;

endmodule
`default_nettype wire

// File: rtl/grid_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : grid_uart_tx
// Description : Reports the game grid and lose flag to a host as an 11-byte
//               ASCII frame (9 cell digits, 'P'/'L', LF). Keeps a snapshot of
//               the last reported state and re-sends on change or request.
//               Build macro: TX_PARITY_EN (even parity per byte).
// Revision    : 1.0 - initial release
// ============================================================================
module grid_uart_tx
  import five12_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_CELLS    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [26:0] grid,
  input  logic        lose,
  input  logic        send,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [3:0] c_LAST_IDX = 4'(NUM_CELLS + 1);

  frame_state_t r_state;
  frame_state_t w_state_nxt;
  logic [3:0]   r_idx;
  logic [26:0]  r_snap_grid;
  logic         r_snap_lose;
  logic         r_pending;

  logic         w_launch;
  logic         w_last;
  logic         w_changed;
  logic         w_byte_start;
  logic         w_byte_done;
  logic [3:0]   w_next_idx;
  logic [26:0]  w_src_grid;
  logic         w_src_lose;
  logic [7:0]   w_byte_data;
  logic         w_frame_done;

  assign w_launch   = (r_state == FRAME_IDLE) && r_pending;
  assign w_last     = (r_idx == c_LAST_IDX);
  assign w_changed  = (grid != r_snap_grid) || (lose != r_snap_lose);

  // The first byte is launched on the same edge that captures the snapshot,
  // so it is encoded from the live inputs; later bytes use the snapshot.
  assign w_next_idx   = (r_state == FRAME_IDLE) ? 4'd0 : r_idx + 4'd1;
  assign w_src_grid   = w_launch ? grid : r_snap_grid;
  assign w_src_lose   = w_launch ? lose : r_snap_lose;
  assign w_byte_data  = frame_char(w_next_idx, w_src_grid, w_src_lose);
  assign w_byte_start = w_launch || ((r_state == FRAME_NEXT) && !w_last);

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FRAME_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame sequencing: one byte at a time, a one-cycle gap between bytes
  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      FRAME_IDLE: begin
        if (r_pending) begin
          w_state_nxt = FRAME_BYTE;
        end
      end
      FRAME_BYTE: begin
        if (w_byte_done) begin
          w_state_nxt = FRAME_NEXT;
        end
      end
      FRAME_NEXT: begin
        if (w_last) begin
          w_frame_done = 1'b1;
          w_state_nxt  = FRAME_IDLE;
        end else begin
          w_state_nxt  = FRAME_BYTE;
        end
      end
      default: begin
        w_state_nxt = FRAME_IDLE;
      end
    endcase
  end

  // Snapshot, byte index and pending request; pending starts set so the
  // host sees a frame right after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_snap_grid <= '0;
      r_snap_lose <= 1'b0;
      r_pending   <= 1'b1;
    end else if (w_launch) begin
      r_snap_grid <= grid;
      r_snap_lose <= lose;
      r_idx       <= 4'd0;
      r_pending   <= send;
    end else begin
      if (send || ((r_state == FRAME_IDLE) && w_changed)) begin
        r_pending <= 1'b1;
      end
      if ((r_state == FRAME_NEXT) && !w_last) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_byte_start),
    .i_data  (w_byte_data),
    .o_tx    (tx),
    .o_done  (w_byte_done)
  );

  assign busy       = (r_state != FRAME_IDLE);
  assign frame_done = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_grid_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_grid_uart_tx
// Description : Directed bench for grid_uart_tx with CLKS_PER_BIT=4. Decodes
//               the line at mid-bit and compares frames with hand-written
//               strings. Build macro: TX_PARITY_EN (parity bit and timing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_uart_tx;

  localparam int C = 4;
`ifdef TX_PARITY_EN
  localparam int c_BITS = 11;
`else
  localparam int c_BITS = 10;
`endif
  localparam int c_BYTE  = c_BITS * C + 1;   // 41, or 45 with parity
  localparam int c_FRAME = 11 * c_BYTE;      // 451, or 495 with parity

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        lose = 1'b0;
  logic        send = 1'b0;
  logic [26:0] grid = '0;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  int n_done = 0;

  grid_uart_tx #(
    .CLKS_PER_BIT (C),
    .NUM_CELLS    (9)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .grid       (grid),
    .lose       (lose),
    .send       (send),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Cycle counter and frame_done pulse counter
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) n_done <= n_done + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_send();
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Receive one byte: find the start edge, then sample each bit mid-way
  task automatic rx_byte(output logic [7:0] b, output int t_start, output bit ok);
    int k;
    k = 0;
    b = '0;
    t_start = 0;
    ok = 1'b0;
    while (tx !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_eq("rx_start_edge", 32'(tx), 32'd0);
    if (tx !== 1'b0) return;
    t_start = cyc;
    repeat (C / 2) @(negedge clk);
    check_eq("rx_start_mid", 32'(tx), 32'd0);
    for (int j = 0; j < 8; j++) begin
      repeat (C) @(negedge clk);
      b[j] = tx;
    end
`ifdef TX_PARITY_EN
    repeat (C) @(negedge clk);
    check_eq("rx_parity", 32'(tx), 32'(^b));
`endif
    repeat (C) @(negedge clk);
    check_eq("rx_stop", 32'(tx), 32'd1);
    ok = 1'b1;
  endtask

  task automatic rx_frame(input string tag, input string exp, output int t0);
    logic [7:0] b;
    int         ts;
    int         tprev;
    bit         ok;
    string      e;
    e     = exp;
    t0    = 0;
    tprev = 0;
    for (int i = 0; i < 11; i++) begin
      rx_byte(b, ts, ok);
      if (!ok) return;
      if (i == 0) t0 = ts;
      else if (i == 1) check_eq({tag, "_byte_period"}, 32'(ts - tprev), 32'(c_BYTE));
      tprev = ts;
      check_eq($sformatf("%s_char%0d", tag, i), 32'(b), 32'(e[i]));
    end
  endtask

  // Wait for the frame_done pulse, then check it is one cycle and busy drops
  task automatic wait_done(input string tag, output int t_done);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_done_pulse"}, 32'(frame_done), 32'd1);
    t_done = cyc;
    @(negedge clk);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
    check_eq({tag, "_done_width"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int         t0;
    int         td;
    int         nd0;
    int         k;
    int         ts;
    bit         ok;
    logic [7:0] b;
    string      s5;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_tx",   32'(tx),         32'd1);
    check_eq("rst_busy", 32'(busy),       32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Frame forced by reset, no stimulus; 451 cycles counting both ends
    rx_frame("f1", "000000000P\n", t0);
    wait_done("f1", td);
    check_eq("f1_latency", 32'(td - t0 + 1), 32'(c_FRAME));
    repeat (50) @(negedge clk);
    check_eq("f1_single",  32'(n_done), 32'd1);
    check_eq("f1_idle_tx", 32'(tx),     32'd1);

    // Grid change while idle: cell0=1, cell4=3, cell8=7
    nd0  = n_done;
    grid = 27'o700030001;
    rx_frame("f2", "100030007P\n", t0);
    wait_done("f2", td);
    repeat (50) @(negedge clk);
    check_eq("f2_single", 32'(n_done - nd0), 32'd1);

    // lose rises mid-frame: current frame keeps 'P', one follow-up with 'L'
    nd0 = n_done;
    fork
      begin
        rx_frame("f3a", "100030007P\n", t0);
        rx_frame("f3b", "100030007L\n", t0);
        wait_done("f3b", td);
      end
      begin
        pulse_send();
        repeat (100) @(negedge clk);
        lose = 1'b1;
      end
    join
    repeat (100) @(negedge clk);
    check_eq("f3_count", 32'(n_done - nd0), 32'd2);
    check_eq("f3_idle",  32'(busy),         32'd0);

    // Three send pulses during one frame give exactly one extra frame
    nd0 = n_done;
    fork
      begin
        rx_frame("f4a", "100030007L\n", t0);
        rx_frame("f4b", "100030007L\n", t0);
        wait_done("f4b", td);
      end
      begin
        pulse_send();
        repeat (50) @(negedge clk);
        pulse_send();
        repeat (100) @(negedge clk);
        pulse_send();
        repeat (100) @(negedge clk);
        pulse_send();
      end
    join
    repeat (200) @(negedge clk);
    check_eq("f4_count", 32'(n_done - nd0), 32'd2);

    // Reset during DATA of byte 5 abandons the frame
    nd0 = n_done;
    s5  = "100030007L";
    pulse_send();
    for (int i = 0; i < 5; i++) begin
      rx_byte(b, ts, ok);
      check_eq($sformatf("f5_pre_char%0d", i), 32'(b), 32'(s5[i]));
    end
    k = 0;
    while (tx !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("f5_byte5_start", 32'(tx), 32'd0);
    repeat (2 * C + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("f5_rst_tx",   32'(tx),         32'd1);
    check_eq("f5_rst_busy", 32'(busy),       32'd0);
    check_eq("f5_rst_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    check_eq("f5_no_done", 32'(n_done - nd0), 32'd0);
    rst = 1'b0;
    rx_frame("f5", "100030007L\n", t0);
    wait_done("f5", td);
    repeat (50) @(negedge clk);
    check_eq("f5_count", 32'(n_done - nd0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
